// File: rtl/adc_pkg.sv
// Shared types and frame constants for the MCP3002-style SPI ADC sampler.
package adc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      SCK_HI,
      SCK_LO,
      DONE
   } adc_state_t;

   localparam int FRAME_BITS     = 16;
   localparam int NULL_IDX       = 4;
   localparam int DATA_FIRST_IDX = 5;
   localparam int DATA_LAST_IDX  = 14;
   localparam int CMD_BITS       = 4;
   localparam int DATA_WIDTH     = 10;

   // Bit 0 goes out first: start, single-ended, channel select, MSB-first.
   function automatic logic [FRAME_BITS-1:0] build_cmd(input logic channel);
      logic [FRAME_BITS-1:0] cmd;
      cmd = '0;
      cmd[CMD_BITS-1:0] = {1'b1, channel, 1'b1, 1'b1};
      return cmd;
   endfunction

endpackage

// File: rtl/sample_tick.sv
// Free-running sample-rate divider; pulses tick for one cycle every SAMPLE_DIV cycles.
module sample_tick
   import adc_pkg::*;
#(
   parameter int SAMPLE_DIV = 5000
) (
   input  logic sysclk,
   input  logic rst,
   output logic tick
);

   localparam int CW = $clog2(SAMPLE_DIV);

   logic [CW-1:0] count;

   always_ff @(posedge sysclk) begin
      if (rst) begin
         count <= '0;
      end else if (count == CW'(SAMPLE_DIV - 1)) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

   assign tick = (count == CW'(SAMPLE_DIV - 1));

endmodule

// File: rtl/adc_spi_sampler.sv
// One SPI conversion per sample tick; result held on data_out with a level data_valid.
module adc_spi_sampler
   import adc_pkg::*;
#(
   parameter int   CLK_DIV    = 25,
   parameter int   SAMPLE_DIV = 5000,
   parameter logic CHANNEL    = 1'b0
) (
   input  logic                  sysclk,
   input  logic                  rst,
   input  logic                  adc_dout,
   output logic                  adc_cs,
   output logic                  adc_sck,
   output logic                  adc_din,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid
);

   localparam int DW = $clog2(CLK_DIV);
   localparam logic [FRAME_BITS-1:0] CMD = build_cmd(CHANNEL);

   adc_state_t            state;
   adc_state_t            next_state;
   logic [DW-1:0]         div_cnt;
   logic [3:0]            bit_idx;
   logic [DATA_WIDTH-1:0] rx_shift;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  valid_q;
   logic                  din_q;
   logic                  dout_meta;
   logic                  dout_sync;
   logic                  tick;
   logic                  phase_end;
   logic                  last_bit;
   logic                  in_data_window;
   logic                  next_cmd_bit;

   sample_tick #(
      .SAMPLE_DIV(SAMPLE_DIV)
   ) u_sample_tick (
      .sysclk(sysclk),
      .rst   (rst),
      .tick  (tick)
   );

   assign phase_end      = (div_cnt == DW'(CLK_DIV - 1));
   assign last_bit       = (bit_idx == 4'(FRAME_BITS - 1));
   assign in_data_window = (bit_idx >= 4'(DATA_FIRST_IDX)) && (bit_idx <= 4'(DATA_LAST_IDX));
   assign next_cmd_bit   = last_bit ? 1'b0 : CMD[bit_idx + 4'd1];

   always_ff @(posedge sysclk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Chip select and SCK are pure state decodes so their edges line up with phase boundaries.
   always_comb begin
      next_state = state;
      adc_cs     = 1'b1;
      adc_sck    = 1'b0;
      case (state)
         IDLE: begin
            if (tick) next_state = START;
         end
         START: begin
            adc_cs = 1'b0;
            if (phase_end) next_state = SCK_HI;
         end
         SCK_HI: begin
            adc_cs  = 1'b0;
            adc_sck = 1'b1;
            if (phase_end) next_state = SCK_LO;
         end
         SCK_LO: begin
            adc_cs = 1'b0;
            if (phase_end) next_state = last_bit ? DONE : SCK_HI;
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // MISO crosses in through two flops; the half-period is long enough to absorb the delay.
   always_ff @(posedge sysclk) begin
      if (rst) begin
         dout_meta <= 1'b0;
         dout_sync <= 1'b0;
      end else begin
         dout_meta <= adc_dout;
         dout_sync <= dout_meta;
      end
   end

   // Datapath updates happen on state transitions so valid/data and din coincide with cs/sck edges.
   always_ff @(posedge sysclk) begin
      if (rst) begin
         div_cnt  <= '0;
         bit_idx  <= '0;
         rx_shift <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         din_q    <= 1'b0;
      end else begin
         if (state == IDLE || state == DONE || phase_end) begin
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + DW'(1);
         end
         case (state)
            IDLE: begin
               if (tick) begin
                  din_q   <= CMD[0];
                  valid_q <= 1'b0;
                  bit_idx <= '0;
               end
            end
            SCK_HI: begin
               if (div_cnt == '0 && in_data_window) begin
                  rx_shift <= {rx_shift[DATA_WIDTH-2:0], dout_sync};
               end
               if (phase_end) din_q <= next_cmd_bit;
            end
            SCK_LO: begin
               if (phase_end) begin
                  if (last_bit) begin
                     data_q  <= rx_shift;
                     valid_q <= 1'b1;
                     din_q   <= 1'b0;
                  end else begin
                     bit_idx <= bit_idx + 4'd1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign adc_din    = din_q;
   assign data_out   = data_q;
   assign data_valid = valid_q;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Scoreboard bench: an ADC model serves queued responses per frame and monitors check SPI shape and results.
module tb_adc_spi_sampler;

   localparam int CD = 25;
   localparam int SD = 5000;

   typedef struct {
      logic [15:0] resp;
      logic [9:0]  data;
   } stim_t;

   logic       sysclk = 1'b0;
   logic       rst    = 1'b1;
   logic       rst_q  = 1'b1;
   logic       dout0  = 1'b0;
   logic       dout1  = 1'b0;
   logic       cs0, sck0, din0, valid0;
   logic       cs1, sck1, din1, valid1;
   logic [9:0] data0, data1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int frames_done = 0;
   int rises0 = 0;

   stim_t      stim_q[$];
   logic [9:0] exp_q[$];

   always #5 sysclk = ~sysclk;

   adc_spi_sampler #(.CLK_DIV(CD), .SAMPLE_DIV(SD), .CHANNEL(1'b0)) dut0 (
      .sysclk(sysclk), .rst(rst), .adc_dout(dout0), .adc_cs(cs0), .adc_sck(sck0),
      .adc_din(din0), .data_out(data0), .data_valid(valid0)
   );

   adc_spi_sampler #(.CLK_DIV(CD), .SAMPLE_DIV(SD), .CHANNEL(1'b1)) dut1 (
      .sysclk(sysclk), .rst(rst), .adc_dout(dout1), .adc_cs(cs1), .adc_sck(sck1),
      .adc_din(din1), .data_out(data1), .data_valid(valid1)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
      end
   endtask

   // Response bit k is what the ADC shifts out before SCK rise k; bits 0..3 are junk the DUT must ignore.
   function automatic logic [15:0] make_resp(input logic [9:0] d, input logic null_bit, input logic trail_bit);
      logic [15:0] r;
      r = 16'h0005;
      r[4] = null_bit;
      for (int i = 0; i < 10; i++) r[5 + i] = d[9 - i];
      r[15] = trail_bit;
      return r;
   endfunction

   task automatic applyStimulus(input logic [9:0] d, input logic null_bit, input logic trail_bit);
      stim_t s;
      s.resp = make_resp(d, null_bit, trail_bit);
      s.data = d;
      stim_q.push_back(s);
   endtask

   always @(posedge sysclk) begin
      rst_q <= rst;
      cyc++;
   end

   // ADC model and frame monitor for the CHANNEL=0 instance.
   logic        prev_cs0 = 1'b1, prev_sck0 = 1'b0, prev_valid0 = 1'b0;
   logic        had_frame = 1'b0, sck_bad = 1'b0;
   logic [15:0] cur_resp = '0, din_cap0 = '0;
   logic [9:0]  last_data = '0;
   int          bit_k = 0, hi_len = 0, lo_len = 0, t_csfall = 0;

   always @(negedge sysclk) begin
      stim_t      s;
      logic [9:0] e;
      if (rst_q) begin
         exp_q.delete();
         had_frame = 1'b0;
         last_data = '0;
         rises0    = 0;
         bit_k     = 0;
         dout0     = 1'b0;
      end else begin
         if (cs0 && sck0) sck_bad = 1'b1;
         if (prev_cs0 && !cs0) begin
            checkOutput("valid_fall_with_cs", 32'(valid0), 32'(0));
            checkOutput("valid_held_before_frame", 32'(prev_valid0), 32'(had_frame));
            checkOutput("data_hold", 32'(data0), 32'(last_data));
            checkOutput("sck_idle_low", 32'(sck_bad), 32'(0));
            sck_bad = 1'b0;
            if (stim_q.size() > 0) s = stim_q.pop_front();
            else begin
               s.resp = '0;
               s.data = '0;
            end
            cur_resp = s.resp;
            exp_q.push_back(s.data);
            bit_k    = 0;
            dout0    = cur_resp[0];
            rises0   = 0;
            lo_len   = 1;
            din_cap0 = '0;
            t_csfall = cyc;
         end else if (!cs0) begin
            if (!prev_sck0 && sck0) begin
               checkOutput("sck_low_len", 32'(lo_len), 32'(CD));
               if (rises0 < 16) din_cap0[rises0] = din0;
               rises0++;
               hi_len = 1;
            end else if (prev_sck0 && !sck0) begin
               checkOutput("sck_high_len", 32'(hi_len), 32'(CD));
               bit_k++;
               if (bit_k < 16) dout0 = cur_resp[bit_k];
               lo_len = 1;
            end else if (sck0) hi_len++;
            else lo_len++;
         end
         if (!prev_valid0 && valid0) begin
            checkOutput("cs_high_at_valid", 32'(cs0), 32'(1));
            checkOutput("cs_to_valid_cycles", 32'(cyc - t_csfall), 32'(33 * CD));
            checkOutput("sck_rises", 32'(rises0), 32'(16));
            checkOutput("last_low_len", 32'(lo_len), 32'(CD));
            checkOutput("din_at_rises_ch0", 32'(din_cap0), 32'h000B);
            if (exp_q.size() == 0) checkOutput("unexpected_valid", 32'(1), 32'(0));
            else begin
               e = exp_q.pop_front();
               checkOutput("data_out", 32'(data0), 32'(e));
               last_data = e;
            end
            had_frame = 1'b1;
            frames_done++;
         end
      end
      prev_cs0    = cs0;
      prev_sck0   = sck0;
      prev_valid0 = valid0;
   end

   // Command monitor for the CHANNEL=1 instance; its MISO stays low so every result is zero.
   logic        prev_cs1 = 1'b1, prev_sck1 = 1'b0;
   logic [15:0] din_cap1 = '0;
   int          rises1 = 0;

   always @(negedge sysclk) begin
      if (rst_q) begin
         rises1 = 0;
      end else begin
         if (prev_cs1 && !cs1) begin
            rises1   = 0;
            din_cap1 = '0;
         end else if (!cs1 && !prev_sck1 && sck1) begin
            if (rises1 < 16) din_cap1[rises1] = din1;
            rises1++;
         end
         if (!prev_cs1 && cs1 && rises1 == 16) begin
            checkOutput("din_at_rises_ch1", 32'(din_cap1), 32'h000F);
            checkOutput("data_out_ch1", 32'(data1), 32'(0));
         end
      end
      prev_cs1  = cs1;
      prev_sck1 = sck1;
   end

   task automatic wait_cs_fall(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge sysclk);
         n++;
      end while (cs0 && n < SD + 100);
      checkOutput(tag, 32'(n), 32'(SD));
   endtask

   task automatic wait_frames(input int n);
      int target;
      int t;
      target = frames_done + n;
      t = 0;
      while (frames_done < target && t < n * SD + 2000) begin
         @(negedge sysclk);
         t++;
      end
      checkOutput("frame_timeout", 32'(frames_done >= target), 32'(1));
   endtask

   task automatic check_reset_outputs(input string tag);
      checkOutput({tag, "_cs"}, 32'(cs0), 32'(1));
      checkOutput({tag, "_sck"}, 32'(sck0), 32'(0));
      checkOutput({tag, "_din"}, 32'(din0), 32'(0));
      checkOutput({tag, "_data"}, 32'(data0), 32'(0));
      checkOutput({tag, "_valid"}, 32'(valid0), 32'(0));
   endtask

   initial begin
      int t;
      rst = 1'b1;
      repeat (3) @(negedge sysclk);
      check_reset_outputs("reset");

      applyStimulus(10'h2A5, 1'b0, 1'b0);
      rst = 1'b0;
      wait_cs_fall("first_frame_start");
      wait_frames(1);

      applyStimulus(10'h000, 1'b0, 1'b0);
      applyStimulus(10'h3FF, 1'b0, 1'b0);
      wait_frames(2);

      applyStimulus(10'h001, 1'b1, 1'b1);
      wait_frames(1);

      // One frame is cut short by reset at bit index 8; the same word is queued again for the retry.
      applyStimulus(10'h155, 1'b0, 1'b0);
      applyStimulus(10'h155, 1'b0, 1'b0);
      t = 0;
      while (rises0 != 9 && t < 2 * SD) begin
         @(negedge sysclk);
         t++;
      end
      checkOutput("reached_bit8", 32'(rises0), 32'(9));
      rst = 1'b1;
      @(negedge sysclk);
      check_reset_outputs("midframe_reset");
      rst = 1'b0;
      wait_cs_fall("frame_after_reset");
      wait_frames(1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/adc_spi_sampler.md
# adc_spi_sampler

Front-end sample source for the audio path: a free-running sample timer triggers one SPI conversion on an MCP3002-style 10-bit ADC, assembles the result, and presents it as `data_out` with a level `data_valid`. These outputs connect directly to the `processor` stage's `data_in` / `data_valid` inputs. The `processor` stage edge-detects `data_valid` itself, and removes the offset-binary bias.

## Interface
- `CLK_DIV`, 25: sysclk cycles per SCK half-period (50 MHz sysclk gives 1 MHz SCK). Minimum 4.
- `SAMPLE_DIV`, 5000: sysclk cycles per sample period (10 kHz). Must be at least 33*CLK_DIV+2.
- `CHANNEL`, 1'b0: ADC input channel (ODD/SIGN bit).
- `sysclk` input 1: system clock; the only clock.
- `rst` input 1: synchronous, active-high reset.
- `adc_dout` input 1: ADC serial data (MISO); asynchronous to `sysclk`.
- `adc_cs` output 1: ADC chip select, active low.
- `adc_sck` output 1: SPI clock, idles low.
- `adc_din` output 1: ADC serial command (MOSI).
- `data_out` output 10: last complete conversion, offset binary.
- `data_valid` output 1: level; high from conversion complete until the next frame starts.

## Operation
- **Sample timer**
  - Counter runs 0..SAMPLE_DIV-1 and wraps.
  - `tick` is asserted for one cycle when the count equals SAMPLE_DIV-1.
  - A tick arriving while not in IDLE is ignored; the parameter constraint makes this unreachable.
- **FSM states:** IDLE, START, SCK_HI, SCK_LO, DONE.
- **IDLE:** `adc_cs`=1, `adc_sck`=0, `adc_din`=0. On `tick`, go to START.
- **START:**
  - `adc_cs`=0, `adc_din`=cmd[0], `data_valid`=0.
  - Hold CLK_DIV cycles, then go to SCK_HI with bit index 0.
- **SCK_HI:**
  - `adc_sck`=1 for CLK_DIV cycles.
  - In the first cycle, sample synchronized `adc_dout` into bit k.
  - Then go to SCK_LO.
- **SCK_LO:**
  - `adc_sck`=0 for CLK_DIV cycles.
  - On entry, `adc_din`=cmd[k+1] (0 for k≥3).
  - If k=15, go to DONE after the hold; otherwise k++ and go to SCK_HI.
- **Command bits 0..3:** 1 (start), 1 (single-ended), CHANNEL, 1 (MSBF). Bits 4..15 are 0.
- **Response bits:**
  - Bit 4 is the null bit and is ignored.
  - Bits 5..14 map to D9..D0.
  - Bit 15 is ignored.
- **DONE (one cycle):** `adc_cs`=1, `data_out`=assembled word, `data_valid`=1, then IDLE.
- `data_out` changes only in DONE; it holds between frames.
- `adc_dout` passes through a 2-flop synchronizer. Its 2-cycle delay fits within the half-period because CLK_DIV≥4, and MISO is stable for a full half-period before each rising edge.
- **Reset (any state, including mid-frame):**
  - Next cycle: state IDLE, counters 0.
  - Outputs: `adc_cs`=1, `adc_sck`=0, `adc_din`=0, `data_out`=0, `data_valid`=0.
  - A partial word is discarded.

## Timing
- After reset release, the first `tick` comes SAMPLE_DIV cycles later; ticks then repeat every SAMPLE_DIV cycles.
- `tick` to `adc_cs` falling: 1 cycle.
- `adc_cs` falling to first SCK rise: CLK_DIV cycles.
- Each frame has exactly 16 SCK periods, each CLK_DIV high and CLK_DIV low.
- `tick` to `data_valid` rising: 33*CLK_DIV+1 cycles (826 at defaults).
- `adc_cs` rises in the same cycle that `data_valid` rises.
- `data_valid` falls in the same cycle the next frame's `adc_cs` falls.
- `adc_din` changes only while `adc_sck`=0 or on `adc_cs` falling; it is never within one cycle of an SCK rise.

## Structure
- **Package `adc_pkg`:**
  - State enum `adc_state_t`.
  - Constants FRAME_BITS=16, NULL_IDX=4, DATA_FIRST_IDX=5, DATA_LAST_IDX=14, CMD_BITS=4.
  - Function building the 16-bit command from CHANNEL.
- **Sub-module `sample_tick`:** parameterized SAMPLE_DIV counter with `sysclk`/`rst`, output `tick`.
- **Top:** FSM, half-period counter, bit index, shift register, synchronizer.

## Test plan
- **Single conversion:** ADC model returns 10'h2A5, defaults. `data_out`=10'h2A5 and `data_valid` rises exactly 826 cycles after `tick`.
- **Command check:** with CHANNEL=0, `adc_din` at the first four SCK rises is 1,1,0,1. With CHANNEL=1 it is 1,1,1,1. `adc_din`=0 at all later rises.
- **SCK shape:** per frame, exactly 16 rising edges. Each high phase is 25 cycles and each low phase is 25 cycles. `adc_sck`=0 whenever `adc_cs`=1.
- **Back-to-back frames:** model returns 10'h000, then 10'h3FF.
  - `data_out` holds 10'h000 until the second DONE.
  - `data_valid` falls on the second `adc_cs` fall.
  - `data_valid` rises again with 10'h3FF.
- **Reset mid-frame:** assert `rst` at bit index 8 with the model driving 10'h155.
  - Next cycle: `adc_cs`=1, `adc_sck`=0, `data_out`=0, `data_valid`=0.
  - The next frame starts SAMPLE_DIV cycles after release and returns 10'h155 correctly.
- **Null/trailing bit immunity:** model drives 1 on bits 4 and 15 and data 10'h001. Result is `data_out`=10'h001.
